// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with a destination scoreboard.
// Two requesters (ALU and load unit) compete for one RF write port.
// The LSU wins by default. An ALU starved for STARVE_LIMIT cycles is
// forced through once. One busy bit per register tracks outstanding
// destinations: issue sets the bit and the RF commit clears it.
//
// Handshake: a requester transfers on a posedge where its valid and
// ready are both 1. The ready outputs are combinational from valid,
// and at most one ready is high in any cycle. Valid must not depend
// on ready.
module rf_wb_arbiter #(
  parameter int dataWidth    = 32,
  parameter int AddrWidth    = 5,
  parameter int numReg       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [AddrWidth-1:0] alu_rd,
  input  logic [dataWidth-1:0] alu_data,
  output logic                 alu_ready,
  input  logic                 lsu_valid,
  input  logic [AddrWidth-1:0] lsu_rd,
  input  logic [dataWidth-1:0] lsu_data,
  output logic                 lsu_ready,
  output logic                 RFwrite,
  output logic [AddrWidth-1:0] RegW,
  output logic [dataWidth-1:0] dataW,
  input  logic                 issue_valid,
  input  logic [AddrWidth-1:0] issue_rd,
  input  logic [AddrWidth-1:0] RegA,
  input  logic [AddrWidth-1:0] RegB,
  output logic                 busyA,
  output logic                 busyB,
  output logic                 issue_waw
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]        starve_cnt;
  logic                 force_alu;
  logic                 alu_xfer;
  logic                 lsu_xfer;
  logic                 wb_xfer;
  logic [AddrWidth-1:0] wb_rd;
  logic [dataWidth-1:0] wb_data;
  logic [numReg-1:0]    busy;
  logic [numReg-1:0]    busy_n;
  logic                 issue_hit;

  assign force_alu = (starve_cnt == CW'(STARVE_LIMIT));

  // Grant logic: the LSU has priority unless the ALU is being forced through.
  // Both readies are held low during reset.
  always_comb begin
    lsu_ready = !reset && lsu_valid && !force_alu;
    alu_ready = !reset && alu_valid && (!lsu_valid || force_alu);
  end

  // Select the winning requester's destination and data.
  always_comb begin
    alu_xfer = alu_valid && alu_ready;
    lsu_xfer = lsu_valid && lsu_ready;
    wb_xfer  = alu_xfer || lsu_xfer;
    wb_rd    = lsu_xfer ? lsu_rd   : alu_rd;
    wb_data  = lsu_xfer ? lsu_data : alu_data;
  end

  // Starve counter: counts cycles in which the ALU waits. It saturates and
  // clears once the ALU transfers or stops requesting.
  always_ff @(posedge Clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!alu_valid || alu_xfer) begin
      starve_cnt <= '0;
    end else if (!force_alu) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // RF write port: a transfer to r0 completes but is not written.
  // With no write, RegW and dataW keep their previous values.
  always_ff @(posedge Clk) begin
    if (reset) begin
      RFwrite <= 1'b0;
      RegW    <= '0;
      dataW   <= '0;
    end else begin
      RFwrite <= wb_xfer && (wb_rd != '0);
      if (wb_xfer && (wb_rd != '0)) begin
        RegW  <= wb_rd;
        dataW <= wb_data;
      end
    end
  end

  // Next busy vector: a set from issue beats a clear from the commit on the
  // same register. r0 is never busy.
  always_comb begin
    busy_n = '0;
    for (int i = 1; i < numReg; i++) begin
      busy_n[i] = (issue_valid && (issue_rd == AddrWidth'(i))) ||
                  (busy[i] && !(RFwrite && (RegW == AddrWidth'(i))));
    end
  end

  // Busy bit register.
  always_ff @(posedge Clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_n;
    end
  end

  // Scoreboard queries: plain lookups into the busy vector.
  always_comb begin
    busyA     = 1'b0;
    busyB     = 1'b0;
    issue_hit = 1'b0;
    for (int i = 0; i < numReg; i++) begin
      if (RegA == AddrWidth'(i))     busyA     = busy[i];
      if (RegB == AddrWidth'(i))     busyB     = busy[i];
      if (issue_rd == AddrWidth'(i)) issue_hit = busy[i];
    end
    issue_waw = issue_valid && issue_hit;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: scoreboard lifecycle, starvation
// forcing, r0 writeback, set/clear collision and mid-operation reset.
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          Clk;
  logic          reset;
  logic          alu_valid, lsu_valid, issue_valid;
  logic [AW-1:0] alu_rd, lsu_rd, issue_rd, RegA, RegB, RegW;
  logic [DW-1:0] alu_data, lsu_data, dataW;
  logic          alu_ready, lsu_ready, RFwrite, busyA, busyB, issue_waw;

  int checks;
  int failures;

  rf_wb_arbiter #(.dataWidth(DW), .AddrWidth(AW), .numReg(NR), .STARVE_LIMIT(4)) dut (
    .Clk(Clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .RFwrite(RFwrite), .RegW(RegW), .dataW(dataW),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .RegA(RegA), .RegB(RegB), .busyA(busyA), .busyB(busyB), .issue_waw(issue_waw)
  );

  // Clock and reset.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
    issue_valid = 1'b1; issue_rd = 5'd9;
    RegA = 5'd9; RegB = 5'd0;
    tick();
    tick();
    checks++;
    if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: alu_ready=%b lsu_ready=%b expected 0 0", alu_ready, lsu_ready);
    end
    checks++;
    if (RFwrite !== 1'b0 || RegW !== 5'd0 || dataW !== 32'd0) begin
      failures++;
      $display("FAIL reset_wport: RFwrite=%b RegW=%0d dataW=%h expected 0 0 0", RFwrite, RegW, dataW);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (busyA !== 1'b0) begin
      failures++;
      $display("FAIL reset_issue_ignored: busyA=%b expected 0", busyA);
    end
  endtask

  // Issue reserves r5, LSU writes it back, busy clears on the commit edge.
  task automatic test_scoreboard_wb();
    RegA = 5'd5; RegB = 5'd5;
    issue_valid = 1'b1; issue_rd = 5'd5;  // cycle 0
    tick();
    issue_valid = 1'b0;                   // cycle 1
    #1;
    checks++;
    if (busyA !== 1'b1 || busyB !== 1'b1) begin
      failures++;
      $display("FAIL sb_busy_c1: busyA=%b busyB=%b expected 1 1", busyA, busyB);
    end
    tick();                               // cycle 2
    lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (busyA !== 1'b1 || lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
      failures++;
      $display("FAIL sb_c2: busyA=%b lsu_ready=%b alu_ready=%b expected 1 1 0", busyA, lsu_ready, alu_ready);
    end
    tick();                               // cycle 3
    lsu_valid = 1'b0;
    #1;
    checks++;
    if (RFwrite !== 1'b1 || RegW !== 5'd5 || dataW !== 32'hDEADBEEF || busyA !== 1'b1) begin
      failures++;
      $display("FAIL sb_write_c3: RFwrite=%b RegW=%0d dataW=%h busyA=%b expected 1 5 deadbeef 1",
               RFwrite, RegW, dataW, busyA);
    end
    tick();                               // cycle 4
    #1;
    checks++;
    if (busyA !== 1'b0 || RFwrite !== 1'b0 || RegW !== 5'd5 || dataW !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sb_clear_c4: busyA=%b RFwrite=%b RegW=%0d dataW=%h expected 0 0 5 deadbeef",
               busyA, RFwrite, RegW, dataW);
    end
  endtask

  // Both requesters held valid: LSU for 4 cycles, ALU once, then LSU again.
  task automatic test_starve();
    logic exp_alu;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAAAA0010;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hBBBB0011;
    RegA = 5'd10;
    for (int c = 0; c < 7; c++) begin
      #1;
      exp_alu = (c == 4);
      checks++;
      if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin
        failures++;
        $display("FAIL starve_c%0d: alu_ready=%b lsu_ready=%b expected %b %b",
                 c, alu_ready, lsu_ready, exp_alu, !exp_alu);
      end
      if (c == 5) begin
        checks++;
        if (RFwrite !== 1'b1 || RegW !== 5'd10 || dataW !== 32'hAAAA0010) begin
          failures++;
          $display("FAIL starve_alu_write: RFwrite=%b RegW=%0d dataW=%h expected 1 10 aaaa0010",
                   RFwrite, RegW, dataW);
        end
      end
      tick();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #1;
    checks++;
    if (busyA !== 1'b0 || RegW !== 5'd11) begin
      failures++;
      $display("FAIL starve_nonbusy_wb: busyA=%b RegW=%0d expected 0 11", busyA, RegW);
    end
    tick();
  endtask

  // ALU writeback to r0: handshake completes, nothing written, registers hold.
  task automatic test_rd_zero();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    RegA = 5'd0;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      failures++;
      $display("FAIL rd0_ready: alu_ready=%b lsu_ready=%b expected 1 0", alu_ready, lsu_ready);
    end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++;
    if (RFwrite !== 1'b0 || RegW !== 5'd11 || dataW !== 32'hBBBB0011 || busyA !== 1'b0) begin
      failures++;
      $display("FAIL rd0_write: RFwrite=%b RegW=%0d dataW=%h busyA=%b expected 0 11 bbbb0011 0",
               RFwrite, RegW, dataW, busyA);
    end
  endtask

  // Commit of r7 and a new reservation of r7 on the same edge: r7 stays busy.
  task automatic test_set_clear_same();
    RegA = 5'd7;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    #1;
    checks++;
    if (lsu_ready !== 1'b1 || busyA !== 1'b1) begin
      failures++;
      $display("FAIL setclr_handshake: lsu_ready=%b busyA=%b expected 1 1", lsu_ready, busyA);
    end
    tick();
    lsu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    checks++;
    if (RFwrite !== 1'b1 || RegW !== 5'd7 || issue_waw !== 1'b1) begin
      failures++;
      $display("FAIL setclr_same_cycle: RFwrite=%b RegW=%0d issue_waw=%b expected 1 7 1",
               RFwrite, RegW, issue_waw);
    end
    tick();
    issue_valid = 1'b0;
    #1;
    checks++;
    if (busyA !== 1'b1 || RFwrite !== 1'b0) begin
      failures++;
      $display("FAIL setclr_after: busyA=%b RFwrite=%b expected 1 0", busyA, RFwrite);
    end
  endtask

  // Reset arriving while an LSU request is pending and r3 is busy.
  task automatic test_reset_mid();
    RegA = 5'd3;
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    #1;
    checks++;
    if (busyA !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre_busy: busyA=%b expected 1", busyA);
    end
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h55;
    reset = 1'b1;
    #1;
    checks++;
    if (lsu_ready !== 1'b0 || alu_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_ready: lsu_ready=%b alu_ready=%b expected 0 0", lsu_ready, alu_ready);
    end
    tick();
    reset = 1'b0;
    lsu_valid = 1'b0;
    #1;
    checks++;
    if (RFwrite !== 1'b0 || RegW !== 5'd0 || dataW !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_wport: RFwrite=%b RegW=%0d dataW=%h expected 0 0 0", RFwrite, RegW, dataW);
    end
    for (int r = 0; r < NR; r++) begin
      RegA = AW'(r);
      RegB = AW'(NR - 1 - r);
      #1;
      checks++;
      if (busyA !== 1'b0 || busyB !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_busy_r%0d: busyA=%b busyB=%b expected 0 0", r, busyA, busyB);
      end
    end
  endtask

  // Test sequence and final report.
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    RegA = '0; RegB = '0;
    test_reset();
    test_scoreboard_wb();
    test_starve();
    test_rd_zero();
    test_set_clear_same();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
